// File: rtl/ram64_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram64_bist
// Brief    : Write/read-back self test for a 64 x 16 RAM with address-keyed
//            patterns. Define RAM64_BIST_INV_PASS_EN to add a second,
//            inverted-pattern write/read pass.
// Revision : 1.0 - initial release
// ============================================================================
module ram64_bist (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ram_out,
    output logic [15:0] ram_in,
    output logic [5:0]  ram_addr,
    output logic        ram_load,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  fail_addr,
    output logic [7:0]  err_count
);

    localparam logic [15:0] c_pat0 = 16'hA5A5;
`ifdef RAM64_BIST_INV_PASS_EN
    localparam logic [15:0] c_pat1 = 16'h5A5A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_DONE   = 3'd3,
        S_WRITE2 = 3'd4,
        S_READ2  = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [7:0]  r_err_count;
    logic [5:0]  r_fail_addr;

    logic        w_is_write;
    logic        w_is_read;
    logic [15:0] w_pat;
    logic [15:0] w_exp;
    logic        w_mismatch;
    logic        w_last;

    function automatic logic [15:0] f_expect(input logic [15:0] pat, input logic [5:0] a);
        return pat ^ {a, a, a[3:0]};
    endfunction

    // All RAM-facing signals decode registered state only.
    always_comb begin
        w_is_write = 1'b0;
        w_is_read  = 1'b0;
        w_pat      = c_pat0;
        case (r_state)
            S_WRITE:  w_is_write = 1'b1;
            S_READ:   w_is_read  = 1'b1;
`ifdef RAM64_BIST_INV_PASS_EN
            S_WRITE2: begin
                w_is_write = 1'b1;
                w_pat      = c_pat1;
            end
            S_READ2: begin
                w_is_read  = 1'b1;
                w_pat      = c_pat1;
            end
`endif
            default: ;
        endcase
    end

    assign w_exp      = f_expect(w_pat, r_cnt);
    assign w_mismatch = w_is_read && (ram_out != w_exp);
    assign w_last     = (r_cnt == 6'd63);

    assign busy      = w_is_write | w_is_read;
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err_count == 8'd0);
    assign ram_load  = w_is_write;
    assign ram_addr  = busy ? r_cnt : 6'd0;
    assign ram_in    = w_is_write ? w_exp : 16'd0;
    assign fail_addr = r_fail_addr;
    assign err_count = r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_err_count <= 8'd0;
            r_fail_addr <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WRITE;
                        r_cnt       <= 6'd0;
                        r_err_count <= 8'd0;
                        r_fail_addr <= 6'd0;
                    end
                end
                S_WRITE: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) r_state <= S_READ;
                end
                S_READ: begin
                    r_cnt <= r_cnt + 6'd1;
`ifdef RAM64_BIST_INV_PASS_EN
                    if (w_last) r_state <= S_WRITE2;
`else
                    if (w_last) r_state <= S_DONE;
`endif
                end
`ifdef RAM64_BIST_INV_PASS_EN
                S_WRITE2: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) r_state <= S_READ2;
                end
                S_READ2: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) r_state <= S_DONE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase

            // Saturating count never returns to zero, so zero marks "no mismatch yet".
            if (w_mismatch) begin
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                if (r_err_count == 8'd0)  r_fail_addr <= r_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram64_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram64_bist
// Brief    : Self-checking bench for ram64_bist with a fault-injecting RAM
//            and a timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram64_bist;

`ifdef RAM64_BIST_INV_PASS_EN
    localparam int c_total = 256;
    localparam int c_err2  = 4;
`else
    localparam int c_total = 128;
    localparam int c_err2  = 2;
`endif
    localparam int c_done_cyc = c_total + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ram_out;
    logic [15:0] ram_in;
    logic [5:0]  ram_addr;
    logic        ram_load;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  fail_addr;
    logic [7:0]  err_count;

    int n_chk  = 0;
    int n_fail = 0;
    int fault  = 0;
    int bad_wr = 0;
    bit chk_en = 1'b0;

    logic [15:0] mem   [64];
    logic [15:0] m_mem [64];

    int          m_t, m_err, m_fail;
    bit          m_done;
    int          e_ph, e_a;
    logic [15:0] e_word;
    logic [15:0] e_rd;

    ram64_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ram_out   (ram_out),
        .ram_in    (ram_in),
        .ram_addr  (ram_addr),
        .ram_load  (ram_load),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] view(input logic [15:0] d, input int a, input int mode);
        if (mode == 1 && a == 5) return d | 16'h0001;
        if (mode == 2 && (a == 9 || a == 40)) return 16'h0000;
        return d;
    endfunction

    function automatic logic [15:0] model_word(input bit inv, input int a);
        logic [15:0] pat;
        pat = inv ? 16'h5A5A : 16'hA5A5;
        return pat ^ 16'((a << 10) | (a << 4) | (a % 16));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM with optional stuck/zero read faults
    always_comb ram_out = view(mem[ram_addr], int'(ram_addr), fault);

    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
        if (!rst_n && ram_load) bad_wr <= bad_wr + 1;
    end

    // Reference model: m_t counts active cycles 1..c_total; phases of 64 alternate write/read.
    always_comb begin
        e_ph   = 0;
        e_a    = 0;
        e_word = 16'd0;
        e_rd   = 16'd0;
        if (m_t != 0) begin
            e_ph   = (m_t - 1) / 64;
            e_a    = (m_t - 1) % 64;
            e_word = model_word(e_ph >= 2, e_a);
            e_rd   = view(m_mem[e_a], e_a, fault);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_done <= 1'b0;
            m_err  <= 0;
            m_fail <= 0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t    <= 1;
                m_done <= 1'b0;
                m_err  <= 0;
                m_fail <= 0;
            end
        end else begin
            if (e_ph % 2 == 0) begin
                m_mem[e_a] <= e_word;
            end else if (e_rd != e_word) begin
                m_err <= (m_err < 255) ? m_err + 1 : 255;
                if (m_err == 0) m_fail <= e_a;
            end
            if (m_t == c_total) begin
                m_t    <= 0;
                m_done <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(m_t != 0));
            chk("done",      32'(done),      32'(m_done));
            chk("pass",      32'(pass),      32'(m_done && m_err == 0));
            chk("ram_load",  32'(ram_load),  32'(m_t != 0 && e_ph % 2 == 0));
            chk("ram_addr",  32'(ram_addr),  32'(m_t != 0 ? e_a : 0));
            chk("err_count", 32'(err_count), 32'(m_err));
            chk("fail_addr", 32'(fail_addr), 32'(m_fail));
            if (m_t == 0 || e_ph % 2 == 0)
                chk("ram_in", 32'(ram_in), 32'(m_t != 0 ? e_word : 16'd0));
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in cycle cyc; waits (bounded) for done and checks its latency.
    task automatic run_to_done(input int cyc);
        int c;
        c = cyc;
        while (!done && c < c_done_cyc + 20) begin
            @(negedge clk);
            c++;
        end
        chk("done_latency", 32'(c), 32'(c_done_cyc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_pass",  32'(pass),      32'd0);
        chk("rst_load",  32'(ram_load),  32'd0);
        chk("rst_addr",  32'(ram_addr),  32'd0);
        chk("rst_in",    32'(ram_in),    32'd0);
        chk("rst_err",   32'(err_count), 32'd0);
        chk("rst_faddr", 32'(fail_addr), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fault-free run with write-phase spot checks
        pulse_start();
        repeat (5) @(negedge clk);
        chk("w6_addr", 32'(ram_addr), 32'd5);
        chk("w6_in",   32'(ram_in),   32'h0000B1F0);
        chk("w6_load", 32'(ram_load), 32'd1);
`ifdef RAM64_BIST_INV_PASS_EN
        repeat (128) @(negedge clk);
        chk("w2_addr", 32'(ram_addr), 32'd5);
        chk("w2_in",   32'(ram_in),   32'h00004E0F);
        run_to_done(134);
`else
        run_to_done(6);
`endif
        chk("ok_pass",  32'(pass),      32'd1);
        chk("ok_err",   32'(err_count), 32'd0);
        chk("ok_faddr", 32'(fail_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);

        // Bit0 stuck high at address 5
        fault = 1;
        pulse_start();
        run_to_done(1);
        chk("f1_pass",  32'(pass),      32'd0);
        chk("f1_faddr", 32'(fail_addr), 32'd5);
        chk("f1_err",   32'(err_count), 32'd1);

        // Zero reads at addresses 9 and 40
        fault = 2;
        pulse_start();
        run_to_done(1);
        chk("f2_pass",  32'(pass),      32'd0);
        chk("f2_faddr", 32'(fail_addr), 32'd9);
        chk("f2_err",   32'(err_count), 32'(c_err2));

        // Reset in the middle of WRITE, released with start already high
        fault = 0;
        pulse_start();
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_load", 32'(ram_load), 32'd0);
        chk("ar_busy", 32'(busy),     32'd0);
        chk("ar_err",  32'(err_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_to_done(1);
        chk("ar_pass",   32'(pass),   32'd1);
        chk("ar_nowr",   32'(bad_wr), 32'd0);

        // start held high: one test, then restart from DONE
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        repeat (c_done_cyc - 1) @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("hold_restart_done", 32'(done), 32'd0);
        chk("hold_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        run_to_done(1);
        chk("hold_pass", 32'(pass), 32'd1);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
